microsequencer: RTL and testbench
=================================

# microsequencer

Parametrised micro-program sequencer for the microprogrammed RISC-V core. Holds the micro-PC (`upc`), selects the next micro-address from sequential increment, two opcode dispatch tables, or a return to fetch, and flags illegal opcodes by diverting to a trap micro-state. A retired-instruction counter increments on every return to fetch. The block sits between the instruction register (supplies `op`) and the microcode ROM (consumes `upc`, supplies `addr_ctl`).

## Interface
- `UPC_W`, 4: micro-PC width; must be ≥ 4.
- `TRAP_UPC`, 2^UPC_W−1 (15): micro-address entered on an illegal opcode.
- `CNT_W`, 32: retired-instruction counter width.
- `EXT_EN`, 1: when 1, LUI/AUIPC/JALR dispatch to their states; when 0 they are illegal.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  7  opcode field from the instruction register.
- `addr_ctl`  in  2  next-address control from the microcode ROM: 00 = upc+1, 01 = dispatch 1, 10 = dispatch 2, 11 = fetch (0).
- `stall`  in  1  when high, hold all state (memory wait).
- `upc`  out  UPC_W  current micro-PC.
- `illegal`  out  1  one-cycle pulse, high in the first cycle `upc` = TRAP_UPC after a failed dispatch.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
- Dispatch 1 (decode), indexed by `op`:
  - 0110011 → 6
  - 0010011 → 8
  - 1101111 → 9
  - 1100011 → 10
  - 0000011 / 0100011 → 2
  - 0110111 → 11 (when EXT_EN)
  - 1100111 → 12 (when EXT_EN)
  - 0010111 → 13 (when EXT_EN)
  - anything else → TRAP_UPC, with the illegal event.
- Dispatch 2 (memory address), indexed by `op`:
  - 0000011 → 3
  - 0100011 → 5
  - anything else → TRAP_UPC, with the illegal event.
- Sequential: next = upc + 1, modulo 2^UPC_W (TRAP_UPC + 1 wraps to 0 at default width).
- Fetch: next = 0.
- Retire event: `addr_ctl` = 11, `stall` = 0, `reset` = 0, `upc` ≠ 0 and `upc` ≠ TRAP_UPC. `retired` increments by 1 and wraps modulo 2^CNT_W.
- Trap exit: `addr_ctl` = 11 while at TRAP_UPC returns to 0 without a retire event.
- `stall` = 1 freezes `upc`, `retired` and the dispatch decision; `illegal` is forced 0 during stall cycles.

## Timing
- Reset values: `upc` = 0, `retired` = 0, `illegal` = 0. Reset overrides `stall` and `addr_ctl`.
- Next-address selection is combinational from the current `op` and `addr_ctl`. `upc` updates on the next edge, so latency is 1 cycle and there is no bubble between micro-states.
- `illegal` is registered and asserts in the same cycle `upc` first shows TRAP_UPC:
  - it is high for exactly one cycle unless a further illegal dispatch occurs;
  - if stall rises while `illegal` is high, `illegal` drops and is not reasserted.
- Reset asserted mid-instruction (any `upc`, including TRAP_UPC):
  - next cycle `upc` = 0, counter = 0, `illegal` = 0;
  - no retire event is counted on that edge.
- `op` is sampled only when `addr_ctl` ∈ {01, 10}; its value is ignored otherwise.

## Test plan
- Reset, then R-type: `op`=0110011 with `addr_ctl` sequence 00, 01, 00, 11 → `upc` 0→1→6→7→0; `retired` = 1; `illegal` never high.
- Load path: `op`=0000011 with sequence 00, 01, 10, 00, 11 → `upc` 0→1→2→3→4→0; `retired` increments by 1.
- Illegal opcode: `op`=1111111, `addr_ctl`=01 at `upc`=1 → `upc`=15 with `illegal` high for one cycle. Then `addr_ctl`=11 → `upc`=0 and `retired` unchanged. Repeat with EXT_EN=0 and `op`=0110111 → same trap; with EXT_EN=1 → `upc`=11.
- Stall: assert `stall` for 3 cycles at `upc`=6 with `addr_ctl`=11 → `upc` holds 6 and `retired` holds; on release, `upc`=0 and `retired` +1.
- Wrap: at `upc`=15 with `addr_ctl`=00 → `upc`=0. With CNT_W=4 and 16 retires → `retired` wraps to 0.
- Reset mid-op: assert `reset` at `upc`=9 with `addr_ctl`=11 and `stall`=1 → next cycle `upc`=0, `retired`=0, `illegal`=0.

Source files
------------

// File: rtl/microsequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : microsequencer                                                |
// | Description : Micro-PC sequencer with two opcode dispatch tables, an        |
// |               illegal-opcode trap and a retired-instruction counter.        |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module microsequencer #(
  parameter int               UPC_W    = 4,
  parameter logic [UPC_W-1:0] TRAP_UPC = {UPC_W{1'b1}},
  parameter int               CNT_W    = 32,
  parameter bit               EXT_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [1:0]       addr_ctl,
  input  logic             stall,
  output logic [UPC_W-1:0] upc,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] c_ctl_seq   = 2'b00;
  localparam logic [1:0] c_ctl_disp1 = 2'b01;
  localparam logic [1:0] c_ctl_disp2 = 2'b10;
  localparam logic [1:0] c_ctl_fetch = 2'b11;

  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;

  localparam logic [UPC_W-1:0] c_upc_zero   = '0;
  localparam logic [UPC_W-1:0] c_upc_one    = UPC_W'(1);
  localparam logic [UPC_W-1:0] c_upc_mem    = UPC_W'(2);
  localparam logic [UPC_W-1:0] c_upc_load   = UPC_W'(3);
  localparam logic [UPC_W-1:0] c_upc_store  = UPC_W'(5);
  localparam logic [UPC_W-1:0] c_upc_rtype  = UPC_W'(6);
  localparam logic [UPC_W-1:0] c_upc_itype  = UPC_W'(8);
  localparam logic [UPC_W-1:0] c_upc_jal    = UPC_W'(9);
  localparam logic [UPC_W-1:0] c_upc_branch = UPC_W'(10);
  localparam logic [UPC_W-1:0] c_upc_lui    = UPC_W'(11);
  localparam logic [UPC_W-1:0] c_upc_jalr   = UPC_W'(12);
  localparam logic [UPC_W-1:0] c_upc_auipc  = UPC_W'(13);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [UPC_W-1:0] r_upc;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic [UPC_W-1:0] w_disp1;
  logic             w_disp1_ok;
  logic [UPC_W-1:0] w_disp2;
  logic             w_disp2_ok;
  logic [UPC_W-1:0] w_next;
  logic             w_fail;
  logic             w_retire;

  // Decode table: one micro-routine entry point per instruction class.
  always_comb begin
    w_disp1    = TRAP_UPC;
    w_disp1_ok = 1'b0;
    case (op)
      c_op_rtype:  begin w_disp1 = c_upc_rtype;  w_disp1_ok = 1'b1; end
      c_op_itype:  begin w_disp1 = c_upc_itype;  w_disp1_ok = 1'b1; end
      c_op_jal:    begin w_disp1 = c_upc_jal;    w_disp1_ok = 1'b1; end
      c_op_branch: begin w_disp1 = c_upc_branch; w_disp1_ok = 1'b1; end
      c_op_load,
      c_op_store:  begin w_disp1 = c_upc_mem;    w_disp1_ok = 1'b1; end
      c_op_lui:    if (EXT_EN) begin w_disp1 = c_upc_lui;   w_disp1_ok = 1'b1; end
      c_op_jalr:   if (EXT_EN) begin w_disp1 = c_upc_jalr;  w_disp1_ok = 1'b1; end
      c_op_auipc:  if (EXT_EN) begin w_disp1 = c_upc_auipc; w_disp1_ok = 1'b1; end
      default:     begin w_disp1 = TRAP_UPC;     w_disp1_ok = 1'b0; end
    endcase
  end

  // Memory-address table: splits the shared address micro-state into load/store.
  always_comb begin
    w_disp2    = TRAP_UPC;
    w_disp2_ok = 1'b0;
    case (op)
      c_op_load:  begin w_disp2 = c_upc_load;  w_disp2_ok = 1'b1; end
      c_op_store: begin w_disp2 = c_upc_store; w_disp2_ok = 1'b1; end
      default:    begin w_disp2 = TRAP_UPC;    w_disp2_ok = 1'b0; end
    endcase
  end

  always_comb begin
    w_next = c_upc_zero;
    w_fail = 1'b0;
    case (addr_ctl)
      c_ctl_seq:   w_next = r_upc + c_upc_one;
      c_ctl_disp1: begin w_next = w_disp1; w_fail = ~w_disp1_ok; end
      c_ctl_disp2: begin w_next = w_disp2; w_fail = ~w_disp2_ok; end
      c_ctl_fetch: w_next = c_upc_zero;
      default:     w_next = c_upc_zero;
    endcase
  end

  // Leaving the idle or trap state through fetch does not complete an instruction.
  assign w_retire = (addr_ctl == c_ctl_fetch) && (r_upc != c_upc_zero) && (r_upc != TRAP_UPC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_upc     <= c_upc_zero;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else if (stall) begin
      r_illegal <= 1'b0;
    end else begin
      r_upc     <= w_next;
      r_illegal <= w_fail;
      if (w_retire) begin
        r_retired <= r_retired + c_cnt_one;
      end
    end
  end

  assign upc     = r_upc;
  assign illegal = r_illegal & ~stall;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// Randomized and directed bench for microsequencer; three instances (default,
// no extensions, 4-bit counter) share stimulus and are scored against a model.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [6:0] op;
  logic [1:0] addr_ctl;

  logic [3:0]  upc_o [3];
  logic        ill_o [3];
  logic [31:0] ret_o [3];
  logic [3:0]  ret_c4;

  always #5 clk = ~clk;

  microsequencer dut_def (
    .clk(clk), .reset(reset), .op(op), .addr_ctl(addr_ctl), .stall(stall),
    .upc(upc_o[0]), .illegal(ill_o[0]), .retired(ret_o[0])
  );

  microsequencer #(.EXT_EN(1'b0)) dut_noext (
    .clk(clk), .reset(reset), .op(op), .addr_ctl(addr_ctl), .stall(stall),
    .upc(upc_o[1]), .illegal(ill_o[1]), .retired(ret_o[1])
  );

  microsequencer #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .op(op), .addr_ctl(addr_ctl), .stall(stall),
    .upc(upc_o[2]), .illegal(ill_o[2]), .retired(ret_c4)
  );

  assign ret_o[2] = {28'd0, ret_c4};

  int errors = 0;
  int checks = 0;

  int              m_upc [3];
  longint unsigned m_ret [3];
  bit              m_ill [3];
  bit              m_ext [3] = '{1'b1, 1'b0, 1'b1};
  longint unsigned m_mod [3] = '{64'd1 << 32, 64'd1 << 32, 64'd16};

  localparam int TRAP = 15;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Entry point from the opcode tables; -1 means the opcode is not recognised.
  function automatic int target(input int ctl, input logic [6:0] o, input bit ext);
    if (ctl == 1) begin
      case (o)
        7'b0110011: return 6;
        7'b0010011: return 8;
        7'b1101111: return 9;
        7'b1100011: return 10;
        7'b0000011: return 2;
        7'b0100011: return 2;
        7'b0110111: return ext ? 11 : -1;
        7'b1100111: return ext ? 12 : -1;
        7'b0010111: return ext ? 13 : -1;
        default:    return -1;
      endcase
    end
    if (o == 7'b0000011) return 3;
    if (o == 7'b0100011) return 5;
    return -1;
  endfunction

  task automatic model_step(input bit r, input logic [6:0] o, input int c, input bit s);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_upc[i] = 0; m_ret[i] = 0; m_ill[i] = 0;
      end else if (s) begin
        m_ill[i] = 0;
      end else begin
        if (c == 3 && m_upc[i] != 0 && m_upc[i] != TRAP)
          m_ret[i] = (m_ret[i] + 1) % m_mod[i];
        m_ill[i] = 0;
        case (c)
          0: m_upc[i] = (m_upc[i] + 1) % 16;
          3: m_upc[i] = 0;
          default: begin
            int t;
            t = target(c, o, m_ext[i]);
            if (t < 0) begin m_upc[i] = TRAP; m_ill[i] = 1; end
            else m_upc[i] = t;
          end
        endcase
      end
    end
  endtask

  // Apply inputs for one cycle, check current outputs, then advance one edge.
  task automatic cycle(input bit r, input logic [6:0] o, input logic [1:0] c, input bit s);
    reset = r; op = o; addr_ctl = c; stall = s;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("upc[%0d]", i), 64'(upc_o[i]), 64'(m_upc[i]));
      check($sformatf("retired[%0d]", i), 64'(ret_o[i]), m_ret[i]);
      check($sformatf("illegal[%0d]", i), 64'(ill_o[i]), 64'(m_ill[i] && !s));
    end
    @(posedge clk);
    model_step(r, o, int'(c), s);
    @(negedge clk);
  endtask

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] BAD = 7'b1111111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] JAL = 7'b1101111;

  logic [6:0] pool [12] = '{7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0110111, 7'b1100111,
                            7'b0010111, 7'b1111111, 7'b0000000, 7'b1010101};

  initial begin
    reset = 1'b1; stall = 1'b0; op = '0; addr_ctl = 2'b00;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin m_upc[i] = 0; m_ret[i] = 0; m_ill[i] = 0; end
    reset = 1'b1; addr_ctl = 2'b11; stall = 1'b1;
    #1;
    check("reset_upc", 64'(upc_o[0]), 64'd0);
    check("reset_retired", 64'(ret_o[0]), 64'd0);
    check("reset_illegal", 64'(ill_o[0]), 64'd0);
    cycle(1'b1, R, 2'b00, 1'b0);

    // R-type
    cycle(0, R, 2'b00, 0);
    cycle(0, R, 2'b01, 0);
    check("rtype_dispatch", 64'(upc_o[0]), 64'd6);
    cycle(0, R, 2'b00, 0);
    cycle(0, R, 2'b11, 0);
    check("rtype_retired", 64'(ret_o[0]), 64'd1);

    // Load path
    cycle(0, LD, 2'b00, 0);
    cycle(0, LD, 2'b01, 0);
    cycle(0, LD, 2'b10, 0);
    check("load_disp2", 64'(upc_o[0]), 64'd3);
    cycle(0, LD, 2'b00, 0);
    cycle(0, LD, 2'b11, 0);
    check("load_retired", 64'(ret_o[0]), 64'd2);

    // Illegal opcode and trap exit
    cycle(0, BAD, 2'b00, 0);
    cycle(0, BAD, 2'b01, 0);
    check("trap_upc", 64'(upc_o[0]), 64'd15);
    check("trap_illegal", 64'(ill_o[0]), 64'd1);
    cycle(0, BAD, 2'b11, 0);
    check("trap_exit_upc", 64'(upc_o[0]), 64'd0);
    check("trap_exit_retired", 64'(ret_o[0]), 64'd2);

    // LUI with and without extensions
    cycle(0, LUI, 2'b00, 0);
    cycle(0, LUI, 2'b01, 0);
    check("lui_ext", 64'(upc_o[0]), 64'd11);
    check("lui_noext_upc", 64'(upc_o[1]), 64'd15);
    check("lui_noext_illegal", 64'(ill_o[1]), 64'd1);
    cycle(0, LUI, 2'b11, 0);

    // Stall holds fetch for three cycles
    cycle(0, R, 2'b00, 0);
    cycle(0, R, 2'b01, 0);
    for (int k = 0; k < 3; k++) cycle(0, R, 2'b11, 1);
    check("stall_upc", 64'(upc_o[0]), 64'd6);
    check("stall_retired", 64'(ret_o[0]), 64'd3);
    cycle(0, R, 2'b11, 0);
    check("stall_release", 64'(ret_o[0]), 64'd4);

    // Stall rising while illegal is high
    cycle(0, BAD, 2'b00, 0);
    cycle(0, BAD, 2'b01, 0);
    cycle(0, BAD, 2'b00, 1);
    cycle(0, BAD, 2'b00, 0);
    check("wrap_upc", 64'(upc_o[0]), 64'd0);

    // 16 retires wrap the 4-bit counter
    for (int k = 0; k < 16; k++) begin
      cycle(0, R, 2'b00, 0);
      cycle(0, R, 2'b11, 0);
    end
    check("cnt4_wrap", 64'(ret_o[2]), 64'd4);

    // Reset mid-instruction overrides stall and fetch
    cycle(0, JAL, 2'b00, 0);
    cycle(0, JAL, 2'b01, 0);
    check("jal_upc", 64'(upc_o[0]), 64'd9);
    cycle(1, JAL, 2'b11, 1);
    check("midreset_upc", 64'(upc_o[0]), 64'd0);
    check("midreset_retired", 64'(ret_o[0]), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [6:0] o;
      o = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pool[$urandom_range(0, 11)];
      cycle($urandom_range(0, 59) == 0, o, 2'($urandom_range(0, 3)),
            $urandom_range(0, 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
